qdr_lvds_rx: RTL and testbench

Receive-side deserializer for the 4-lane QDR LVDS DAC link. The transmitter sends each 14-bit word as four nibbles on DA, one nibble per DACLK edge, and DAFRAME marks the word boundaries. This block oversamples DA, DAFRAME and DACLK in its own clk domain, finds word alignment from DAFRAME, and rebuilds the 14-bit words. Link status is reported as a three-state lock machine with error accounting. It sits at the far end of the link, for loopback checking and for board-to-board capture.

---
 rtl/qdr_lvds_pkg.sv | 22 ++
 rtl/qdr_lvds_rx_sync.sv | 43 ++++
 rtl/qdr_lvds_rx.sv | 149 ++++++++++++++
 tb/tb_qdr_lvds_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr_lvds_pkg.sv
// Shared types and constants for the QDR LVDS receive path.
// Frame pattern is read MSB-first: slot0 sees bit 3.
package qdr_lvds_pkg;

  localparam int DATA_W = 14;
  localparam int NIB_W  = 4;

  localparam logic [3:0] FRAME_PATTERN = 4'b1100;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } rx_state_t;

  typedef logic [1:0] slot_t;

  function automatic logic exp_frame(input slot_t s);
    return FRAME_PATTERN[~s];
  endfunction

endpackage

// File: rtl/qdr_lvds_rx_sync.sv
// Input synchronizers, one history flop and DACLK edge detect.
// Capture values come from the history flop, one cycle before the edge.
module qdr_lvds_rx_sync
  import qdr_lvds_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIB_W-1:0] da,
  input  logic             daframe,
  input  logic             daclk,
  output logic             daclk_edge,
  output logic [NIB_W-1:0] nibble_d,
  output logic             frame_d
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int W      = NIB_W + 2;

  logic [W-1:0] chain [STAGES];
  logic [W-1:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
      hist <= '0;
    end else begin
      chain[0] <= {daclk, daframe, da};
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      hist <= chain[STAGES-1];
    end
  end

  assign daclk_edge = chain[STAGES-1][W-1] ^ hist[W-1];
  assign nibble_d   = hist[NIB_W-1:0];
  assign frame_d    = hist[NIB_W];

endmodule

// File: rtl/qdr_lvds_rx.sv
// QDR LVDS deserializer: frame alignment, word rebuild, lock FSM.
// Define QDR_RX_PAD_CHECK_EN to treat nonzero slot3 pad bits as errors.
module qdr_lvds_rx
  import qdr_lvds_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_WORDS  = 4,
  parameter int TIMEOUT     = 64,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIB_W-1:0]  da,
  input  logic              daframe,
  input  logic              daclk,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic              frame_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(LOCK_WORDS + 1);

  logic             clk_edge;
  logic [NIB_W-1:0] nib;
  logic             frm;

  qdr_lvds_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .da        (da),
    .daframe   (daframe),
    .daclk     (daclk),
    .daclk_edge(clk_edge),
    .nibble_d  (nib),
    .frame_d   (frm)
  );

  rx_state_t         state;
  slot_t             slot;
  logic [CNT_W-1:0]  good_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              prev_frame;
  logic [DATA_W-3:0] word;

  logic pad_bad;
  logic busy;
  logic mis;
  logic cand;
  logic tmo_go;
  logic hunt_eval;
  logic advance;

`ifdef QDR_RX_PAD_CHECK_EN
  assign pad_bad = (slot == 2'd3) && (nib[1:0] != 2'b00);
`else
  logic unused_pad;
  assign unused_pad = ^nib[1:0];
  assign pad_bad    = 1'b0;
`endif

  assign busy = (state != HUNT);
  assign mis  = clk_edge && busy &&
                ((frm != exp_frame(slot)) || pad_bad);
  assign cand = frm && !prev_frame;

  // An edge always clears the counter, so timeout and mismatch are exclusive
  assign tmo_go    = busy && !clk_edge &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign hunt_eval = clk_edge && (!busy || mis);
  assign advance   = clk_edge && busy && !mis;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      slot       <= '0;
      good_cnt   <= '0;
      tmo_cnt    <= '0;
      prev_frame <= 1'b0;
      word       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (clk_edge) begin
        tmo_cnt    <= '0;
        prev_frame <= frm;
      end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (mis) begin
        frame_err <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
      end

      unique case (1'b1)
        tmo_go: begin
          state <= HUNT;
          slot  <= '0;
        end
        hunt_eval: begin
          if (cand) begin
            state        <= SYNC;
            slot         <= 2'd1;
            good_cnt     <= '0;
            word[11:8]   <= nib;
          end else begin
            state <= HUNT;
            slot  <= '0;
          end
        end
        advance: begin
          slot <= slot + 1'b1;
          unique case (slot)
            2'd0: word[11:8] <= nib;
            2'd1: word[7:4]  <= nib;
            2'd2: word[3:0]  <= nib;
            2'd3: begin
              if (state == LOCKED) begin
                data_out   <= {word, nib[3:2]};
                data_valid <= 1'b1;
              end else if (good_cnt == CNT_W'(LOCK_WORDS - 1)) begin
                state <= LOCKED;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qdr_lvds_rx.sv
// Self-checking bench for qdr_lvds_rx: vector table, corner sequences,
// and randomized words checked against a word-level lock model.
module tb_qdr_lvds_rx;

  localparam int LOCK_WORDS = 4;
  localparam int TIMEOUT    = 64;
  localparam int ERR_W      = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       da = 4'h0;
  logic             daframe = 1'b0;
  logic             daclk = 1'b0;
  logic [13:0]      data_out;
  logic             data_valid;
  logic             locked;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;

  qdr_lvds_rx #(
    .SYNC_STAGES(2),
    .LOCK_WORDS (LOCK_WORDS),
    .TIMEOUT    (TIMEOUT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .da        (da),
    .daframe   (daframe),
    .daclk     (daclk),
    .data_out  (data_out),
    .data_valid(data_valid),
    .locked    (locked),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int hp     = 2;

  logic [13:0] got_q[$];
  int          err_seen = 0;
  int          rd = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) got_q.push_back(data_out);
      if (frame_err) err_seen++;
    end
  end

  typedef struct {
    logic [13:0] w;
    logic [1:0]  pad;
    int          cor;
    bit          valid;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] n, input logic f);
    da      = n;
    daframe = f;
    repeat (hp / 2) @(negedge clk);
    daclk = ~daclk;
    repeat (hp - hp / 2) @(negedge clk);
  endtask

  // cor: 0 clean, 1 slot1 frame forced 0, 2 slot2 frame forced 1
  task automatic send_word(input logic [13:0] w, input logic [1:0] pad,
                           input int cor);
    logic [3:0] n3;
    n3 = {w[1:0], pad};
    send_nib(w[13:10], 1'b1);
    send_nib(w[9:6], (cor == 1) ? 1'b0 : 1'b1);
    send_nib(w[5:2], (cor == 2) ? 1'b1 : 1'b0);
    send_nib(n3, 1'b0);
  endtask

  task automatic expect_next(input string name, input logic [13:0] w);
    if (rd < got_q.size()) begin
      check(name, got_q[rd], w);
      rd++;
    end else begin
      check({name, "_missing"}, got_q.size(), rd + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    da      = 4'h0;
    daframe = 1'b0;
    daclk   = 1'b0;
    idle(3);
    reset = 1'b0;
    rd = got_q.size();
  endtask

  initial begin
    int base;
    int run;
    int err_exp;
    logic [13:0] exp_q[$];
    logic [13:0] w;
    logic [1:0]  pad;
    int          cor;
    bit          bad;

    idle(3);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b0;

    repeat (3) send_word(14'h2A5C, 2'b00, 0);
    idle(8);
    check("unlocked_after_3", locked, 0);
    send_word(14'h2A5C, 2'b00, 0);
    idle(8);
    check("locked_after_4", locked, 1);
    check("no_valid_in_sync", got_q.size(), 0);

    tbl.push_back('{14'h2A5C, 2'b00, 0, 1'b1});
    tbl.push_back('{14'h2A5C, 2'b00, 0, 1'b1});
    tbl.push_back('{14'h1555, 2'b00, 1, 1'b0});
    tbl.push_back('{14'h0F0F, 2'b00, 0, 1'b0});
    tbl.push_back('{14'h0F0F, 2'b00, 0, 1'b0});
    tbl.push_back('{14'h0F0F, 2'b00, 0, 1'b0});
    tbl.push_back('{14'h0F0F, 2'b00, 0, 1'b0});
    tbl.push_back('{14'h1234, 2'b00, 0, 1'b1});
    tbl.push_back('{14'h2ABC, 2'b00, 0, 1'b1});
    base = err_seen;
    for (int i = 0; i < tbl.size(); i++) begin
      send_word(tbl[i].w, tbl[i].pad, tbl[i].cor);
    end
    idle(12);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].valid) expect_next($sformatf("tbl_%0d", i), tbl[i].w);
    end
    check("tbl_extra_valid", got_q.size(), rd);
    check("tbl_err_pulses", err_seen - base, 1);
    check("tbl_err_count", err_count, 1);
    check("tbl_relocked", locked, 1);

    base = err_seen;
    idle(50);
    check("tmo_still_locked", locked, 1);
    idle(20);
    check("tmo_unlocked", locked, 0);
    check("tmo_no_err", err_seen - base, 0);
    check("tmo_err_count", err_count, 1);
    repeat (5) send_word(14'h0777, 2'b00, 0);
    idle(12);
    expect_next("tmo_relock_word", 14'h0777);
    check("tmo_extra_valid", got_q.size(), rd);

    hp = 4;
    send_word(14'h3FFF, 2'b00, 0);
    send_word(14'h0000, 2'b00, 0);
    send_word(14'h2001, 2'b00, 0);
    idle(16);
    expect_next("x8_w0", 14'h3FFF);
    expect_next("x8_w1", 14'h0000);
    expect_next("x8_w2", 14'h2001);
    check("x8_extra_valid", got_q.size(), rd);
    hp = 2;

    send_nib(4'hA, 1'b1);
    send_nib(4'h9, 1'b1);
    @(negedge clk);
    reset   = 1'b1;
    da      = 4'h0;
    daframe = 1'b0;
    daclk   = 1'b0;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_locked", locked, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_valid", data_valid, 0);
    idle(3);
    reset = 1'b0;
    rd = got_q.size();
    repeat (5) send_word(14'h1A2B, 2'b00, 0);
    idle(12);
    expect_next("midrst_relock_word", 14'h1A2B);
    check("midrst_locked_again", locked, 1);
    check("midrst_err_clean", err_count, 0);

    send_word(14'h2A5C, 2'b01, 0);
    idle(12);
`ifdef QDR_RX_PAD_CHECK_EN
    check("pad_err_count", err_count, 1);
    check("pad_no_valid", got_q.size(), rd);
    check("pad_unlocked", locked, 0);
`else
    expect_next("pad_ignored", 14'h2A5C);
    check("pad_err_count", err_count, 0);
`endif

    do_reset();
    base    = err_seen;
    run     = 0;
    err_exp = 0;
    for (int k = 0; k < 60; k++) begin
      w   = 14'($urandom_range(0, 16383));
      pad = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cor = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      bad = (cor != 0);
`ifdef QDR_RX_PAD_CHECK_EN
      bad = bad || (pad != 2'b00);
`endif
      if (bad) begin
        err_exp++;
        run = 0;
      end else begin
        run++;
        if (run > LOCK_WORDS) exp_q.push_back(w);
      end
      hp = int'($urandom_range(2, 4));
      send_word(w, pad, cor);
      idle(int'($urandom_range(0, 4)));
    end
    hp = 2;
    idle(16);
    for (int i = 0; i < exp_q.size(); i++) begin
      expect_next($sformatf("rnd_%0d", i), exp_q[i]);
    end
    check("rnd_extra_valid", got_q.size(), rd);
    check("rnd_err_pulses", err_seen - base, err_exp);
    check("rnd_err_count", err_count, err_exp);

    do_reset();
    base = err_seen;
    repeat (260) send_word(14'h0155, 2'b00, 1);
    idle(8);
    check("sat_err_count", err_count, 255);
    check("sat_err_pulses", err_seen - base, 260);
    check("sat_no_valid", got_q.size(), rd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
